// File: rtl/aes256_ctr_sequencer.sv
// AES-256 CTR job sequencer.
//
// Sequences one encryption job through an external CTR datapath. Each job loads
// the key and nonce, streams 4*nblocks plaintext words into the datapath input
// FIFO, and moves result words from the datapath output FIFO to the sink. At most
// one result word is in flight between the datapath and the sink.
//
// Ports:
//   clock, reset           single clock, asynchronous active-high reset
//   start, abort, nblocks  job control; nblocks is latched when start is accepted
//   src_valid/src_data/src_ready   plaintext word source handshake
//   snk_valid/snk_data/snk_ready   result word sink handshake
//   dp_setkey, dp_setnonce         key/nonce load strobes (LOAD cycle)
//   dp_run                         datapath run enable
//   dp_wren/dp_datain              datapath input-word FIFO write
//   dp_rden/dp_dataout             datapath output-word FIFO read (data one cycle later)
//   dp_inwordfull, dp_inblockempty, dp_outblockfull, dp_outwordempty  datapath FIFO flags
//   dp_clear                       datapath flush strobe after an abort
//   busy, done, words_out          job status and delivered-word count
module aes256_ctr_sequencer #(
    parameter int unsigned WSIZE = 32,
    parameter int unsigned NBW   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [NBW-1:0]   nblocks,
    input  logic             src_valid,
    input  logic [WSIZE-1:0] src_data,
    output logic             src_ready,
    output logic             snk_valid,
    output logic [WSIZE-1:0] snk_data,
    input  logic             snk_ready,
    output logic             dp_setkey,
    output logic             dp_setnonce,
    output logic             dp_run,
    output logic             dp_wren,
    output logic [WSIZE-1:0] dp_datain,
    output logic             dp_rden,
    input  logic [WSIZE-1:0] dp_dataout,
    input  logic             dp_inwordfull,
    input  logic             dp_inblockempty,
    input  logic             dp_outblockfull,
    input  logic             dp_outwordempty,
    output logic             dp_clear,
    output logic             busy,
    output logic             done,
    output logic [NBW+1:0]   words_out
);

    localparam int unsigned CW = NBW + 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   total_q;
    logic [CW-1:0]   words_in_q;
    logic [CW-1:0]   words_out_q;
    logic            rd_pend_q;
    logic            snk_valid_q;
    logic [WSIZE-1:0] snk_data_q;
    logic            setkey_q;
    logic            clear_q;
    logic            busy_q;
    logic            done_q;

    logic            accept;
    logic            kill;
    logic            active;
    logic            in_last;
    logic [CW-1:0]   out_claimed;

    assign accept = (state_q == StIdle) & start & ~abort;
    assign kill   = (state_q != StIdle) & abort;
    assign active = (state_q == StStream) | (state_q == StDrain);

    assign src_ready = (state_q == StStream) & ~dp_inwordfull & (words_in_q < total_q);
    assign dp_wren   = src_valid & src_ready;
    assign dp_datain = src_data;
    assign dp_run    = active & ~dp_inblockempty & ~dp_outblockfull;

    // Words already delivered plus the one being fetched; never read past the job end.
    assign out_claimed = words_out_q + CW'(rd_pend_q);
    assign dp_rden     = active & ~dp_outwordempty & ~rd_pend_q & ~snk_valid_q &
                         (out_claimed < total_q);

    assign in_last = dp_wren & ((words_in_q + CW'(1)) == total_q);

    assign snk_valid   = snk_valid_q;
    assign snk_data    = snk_data_q;
    assign dp_setkey   = setkey_q;
    assign dp_setnonce = setkey_q;
    assign dp_clear    = clear_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign words_out   = words_out_q;

    // Control FSM with registered strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            total_q  <= '0;
            setkey_q <= 1'b0;
            clear_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            setkey_q <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
            if (kill) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                clear_q <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (accept) begin
                            state_q  <= StLoad;
                            total_q  <= {nblocks, 2'b00};
                            busy_q   <= 1'b1;
                            setkey_q <= 1'b1;
                        end
                    end
                    StLoad: begin
                        if (total_q == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StStream;
                        end
                    end
                    StStream: begin
                        if (in_last) begin
                            state_q <= StDrain;
                        end
                    end
                    StDrain: begin
                        if ((words_out_q == total_q) && !snk_valid_q) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Word counters and the single-entry output stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            words_in_q  <= '0;
            words_out_q <= '0;
            rd_pend_q   <= 1'b0;
            snk_valid_q <= 1'b0;
            snk_data_q  <= '0;
        end else if (accept) begin
            words_in_q  <= '0;
            words_out_q <= '0;
            rd_pend_q   <= 1'b0;
            snk_valid_q <= 1'b0;
        end else if (kill) begin
            rd_pend_q   <= 1'b0;
            snk_valid_q <= 1'b0;
        end else begin
            if (dp_wren) begin
                words_in_q <= words_in_q + CW'(1);
            end
            if (snk_valid_q && snk_ready) begin
                snk_valid_q <= 1'b0;
                words_out_q <= words_out_q + CW'(1);
            end
            // dp_dataout is valid the cycle after dp_rden; snk_valid is known low here.
            if (rd_pend_q) begin
                snk_data_q  <= dp_dataout;
                snk_valid_q <= 1'b1;
                rd_pend_q   <= 1'b0;
            end else if (dp_rden) begin
                rd_pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes256_ctr_sequencer.sv
module tb_aes256_ctr_sequencer;

    localparam int NBW = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [NBW-1:0] nblocks = '0;
    logic src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic src_ready;
    logic snk_valid;
    logic [31:0] snk_data;
    logic snk_ready = 1'b0;
    logic dp_setkey, dp_setnonce, dp_run, dp_wren, dp_rden, dp_clear, busy, done;
    logic [31:0] dp_datain, dp_dataout;
    logic dp_inwordfull, dp_inblockempty, dp_outblockfull, dp_outwordempty;
    logic [NBW+1:0] words_out;

    // Datapath model state and flags (flags registered so the DUT sees stable values).
    logic m_infull = 1'b0, m_inbempty = 1'b1, m_outbfull = 1'b0, m_outwempty = 1'b1;
    logic [31:0] m_dout = '0;
    logic force_ifull = 1'b0, force_obf = 1'b0;
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    int unsigned ks_idx = 0;

    assign dp_inwordfull   = m_infull | force_ifull;
    assign dp_inblockempty = m_inbempty;
    assign dp_outblockfull = m_outbfull | force_obf;
    assign dp_outwordempty = m_outwempty;
    assign dp_dataout      = m_dout;

    // Bench bookkeeping.
    logic [31:0] src_words[$];
    logic [31:0] got[$];
    int src_idx = 0;
    bit src_rand = 0;
    int snk_mode = 0;
    int wren_cnt = 0, rden_cnt = 0, run_cnt = 0, done_cnt = 0;
    int clear_cnt = 0, key_cnt = 0, snk_cnt = 0;
    int n_total = 0, n_bad = 0;

    aes256_ctr_sequencer #(.WSIZE(32), .NBW(NBW)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .nblocks(nblocks),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
        .dp_setkey(dp_setkey), .dp_setnonce(dp_setnonce), .dp_run(dp_run),
        .dp_wren(dp_wren), .dp_datain(dp_datain), .dp_rden(dp_rden), .dp_dataout(dp_dataout),
        .dp_inwordfull(dp_inwordfull), .dp_inblockempty(dp_inblockempty),
        .dp_outblockfull(dp_outblockfull), .dp_outwordempty(dp_outwordempty),
        .dp_clear(dp_clear), .busy(busy), .done(done), .words_out(words_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ks(input int unsigned i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // CTR datapath model: 8-word input FIFO, 8-word output FIFO, block-wise keystream XOR.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            in_q.delete();
            out_q.delete();
            ks_idx = 0;
            m_dout <= '0;
        end else if (dp_clear) begin
            in_q.delete();
            out_q.delete();
        end else begin
            if (dp_setkey) ks_idx = 0;
            if (dp_wren) in_q.push_back(dp_datain);
            if (dp_run && in_q.size() >= 4) begin
                for (int k = 0; k < 4; k++) begin
                    out_q.push_back(in_q.pop_front() ^ ks(ks_idx));
                    ks_idx++;
                end
            end
            if (dp_rden && out_q.size() > 0) m_dout <= out_q.pop_front();
        end
        m_infull    <= (in_q.size() >= 8);
        m_inbempty  <= (in_q.size() < 4);
        m_outbfull  <= (out_q.size() > 4);
        m_outwempty <= (out_q.size() == 0);
    end

    // Event monitor (reads pre-edge values).
    always @(posedge clock) begin
        if (!reset) begin
            if (dp_wren) wren_cnt++;
            if (dp_rden) rden_cnt++;
            if (dp_run) run_cnt++;
            if (done) done_cnt++;
            if (dp_clear) clear_cnt++;
            if (dp_setkey && dp_setnonce) key_cnt++;
            if (snk_valid && snk_ready) begin
                got.push_back(snk_data);
                snk_cnt++;
            end
            if (src_valid && src_ready) src_idx++;
        end
    end

    // Source and sink drivers.
    always @(negedge clock) begin
        src_valid = (src_idx < src_words.size()) && (!src_rand || ($urandom_range(0, 3) != 0));
        src_data  = (src_idx < src_words.size()) ? src_words[src_idx] : 32'hDEADBEEF;
        case (snk_mode)
            0:       snk_ready = 1'b1;
            1:       snk_ready = 1'($urandom_range(0, 1));
            default: snk_ready = 1'b0;
        endcase
    end

    task automatic clear_counts();
        wren_cnt = 0; rden_cnt = 0; run_cnt = 0; done_cnt = 0;
        clear_cnt = 0; key_cnt = 0; snk_cnt = 0;
        got.delete();
    endtask

    task automatic start_job(input int n);
        clear_counts();
        src_words.delete();
        for (int i = 0; i < 4 * n; i++) src_words.push_back($urandom);
        src_idx = 0;
        nblocks = n[NBW-1:0];
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && done_cnt == 0; c++) @(negedge clock);
        repeat (4) @(negedge clock);
    endtask

    function automatic int data_errs(input int n);
        int e = 0;
        if (got.size() != 4 * n) return 999;
        for (int i = 0; i < 4 * n; i++)
            if (got[i] !== (src_words[i] ^ ks(i))) e++;
        return e;
    endfunction

    task automatic test_reset();
        logic [8:0] outs;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        outs = {src_ready, snk_valid, dp_setkey, dp_setnonce, dp_run, dp_wren, dp_rden,
                dp_clear, busy};
        n_total++;
        if (outs !== 9'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b/%b want 0/0", outs, done);
        end
        n_total++;
        if (words_out !== '0 || snk_data !== '0) begin
            n_bad++; $display("FAIL reset_counts: got %0d/%h want 0/0", words_out, snk_data);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int e;
        src_rand = 0; snk_mode = 0;
        start_job(2);
        wait_done(500);
        e = data_errs(2);
        n_total++;
        if (key_cnt !== 1) begin n_bad++; $display("FAIL basic_setkey: got %0d want 1", key_cnt); end
        n_total++;
        if (wren_cnt !== 8) begin n_bad++; $display("FAIL basic_wren: got %0d want 8", wren_cnt); end
        n_total++;
        if (snk_cnt !== 8) begin n_bad++; $display("FAIL basic_sink: got %0d want 8", snk_cnt); end
        n_total++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
        n_total++;
        if (words_out !== 18'd8) begin
            n_bad++; $display("FAIL basic_words_out: got %0d want 8", words_out);
        end
        n_total++;
        if (e !== 0) begin n_bad++; $display("FAIL basic_data: got %0d errors want 0", e); end
        n_total++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_zero();
        src_rand = 0; snk_mode = 0;
        start_job(0);
        n_total++;
        if (dp_setkey !== 1'b1 || dp_setnonce !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL zero_load: got %b%b%b want 111", dp_setkey, dp_setnonce, busy);
        end
        @(negedge clock);
        n_total++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
        @(negedge clock);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL zero_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        repeat (3) @(negedge clock);
        n_total++;
        if (wren_cnt + rden_cnt + run_cnt !== 0 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL zero_activity: got wren=%0d rden=%0d run=%0d done=%0d want 0 0 0 1",
                     wren_cnt, rden_cnt, run_cnt, done_cnt);
        end
    endtask

    task automatic test_sink_stall();
        logic [31:0] held;
        int rd0, unstable = 0, waited = 0, e;
        src_rand = 0; snk_mode = 2;
        start_job(1);
        while (snk_valid !== 1'b1 && waited < 200) begin @(negedge clock); waited++; end
        held = snk_data;
        rd0 = rden_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (snk_data !== held || snk_valid !== 1'b1) unstable++;
        end
        n_total++;
        if (held !== (src_words[0] ^ ks(0))) begin
            n_bad++; $display("FAIL stall_first_word: got %h want %h", held, src_words[0] ^ ks(0));
        end
        n_total++;
        if (unstable !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", unstable); end
        n_total++;
        if (rden_cnt !== rd0) begin n_bad++; $display("FAIL stall_rden: got %0d want %0d", rden_cnt, rd0); end
        snk_mode = 0;
        wait_done(500);
        e = data_errs(1);
        n_total++;
        if (e !== 0 || done_cnt !== 1) begin
            n_bad++; $display("FAIL stall_release: got errs=%0d done=%0d want 0 1", e, done_cnt);
        end
    endtask

    task automatic test_inword_full();
        int viol = 0, waited = 0, e;
        src_rand = 0; snk_mode = 1;
        start_job(3);
        while (wren_cnt < 2 && waited < 200) begin @(negedge clock); waited++; end
        force_ifull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (src_ready !== 1'b0 || dp_wren !== 1'b0) viol++;
            @(negedge clock);
        end
        force_ifull = 1'b0;
        n_total++;
        if (viol !== 0) begin n_bad++; $display("FAIL ifull_block: got %0d violations want 0", viol); end
        wait_done(1000);
        e = data_errs(3);
        n_total++;
        if (e !== 0 || wren_cnt !== 12 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL ifull_result: got errs=%0d wren=%0d done=%0d want 0 12 1",
                     e, wren_cnt, done_cnt);
        end
    endtask

    task automatic test_outblock_full();
        int e;
        src_rand = 0; snk_mode = 0;
        force_obf = 1'b1;
        start_job(3);
        repeat (20) @(negedge clock);
        n_total++;
        if (run_cnt !== 0 || wren_cnt !== 8) begin
            n_bad++; $display("FAIL obf_stall: got run=%0d wren=%0d want 0 8", run_cnt, wren_cnt);
        end
        force_obf = 1'b0;
        wait_done(1000);
        e = data_errs(3);
        n_total++;
        if (e !== 0 || done_cnt !== 1) begin
            n_bad++; $display("FAIL obf_result: got errs=%0d done=%0d want 0 1", e, done_cnt);
        end
    endtask

    task automatic test_abort();
        int waited = 0, e;
        src_rand = 0; snk_mode = 1;
        start_job(4);
        while (wren_cnt < 3 && waited < 200) begin @(negedge clock); waited++; end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_total++;
        if (busy !== 1'b0 || dp_clear !== 1'b1) begin
            n_bad++; $display("FAIL abort_idle: got busy=%b clear=%b want 0 1", busy, dp_clear);
        end
        repeat (5) @(negedge clock);
        n_total++;
        if (clear_cnt !== 1 || done_cnt !== 0 || snk_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_effects: got clear=%0d done=%0d snk_valid=%b want 1 0 0",
                     clear_cnt, done_cnt, snk_valid);
        end
        snk_mode = 0;
        start_job(1);
        wait_done(500);
        e = data_errs(1);
        n_total++;
        if (e !== 0 || done_cnt !== 1 || words_out !== 18'd4) begin
            n_bad++;
            $display("FAIL abort_restart: got errs=%0d done=%0d words=%0d want 0 1 4",
                     e, done_cnt, words_out);
        end
    endtask

    task automatic test_start_abort_idle();
        clear_counts();
        nblocks = 16'd2;
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clock);
        n_total++;
        if (busy !== 1'b0 || clear_cnt !== 0 || key_cnt !== 0) begin
            n_bad++;
            $display("FAIL start_abort_idle: got busy=%b clear=%0d key=%0d want 0 0 0",
                     busy, clear_cnt, key_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int waited = 0;
        src_rand = 0; snk_mode = 0;
        start_job(2);
        for (int i = 0; i < 40; i++) src_words.push_back($urandom);
        while (wren_cnt < 1 && waited < 200) begin @(negedge clock); waited++; end
        nblocks = 16'd7;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(1000);
        n_total++;
        if (wren_cnt !== 8 || snk_cnt !== 8 || words_out !== 18'd8 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL start_ignored: got wren=%0d snk=%0d words=%0d done=%0d want 8 8 8 1",
                     wren_cnt, snk_cnt, words_out, done_cnt);
        end
    endtask

    task automatic test_random_jobs();
        int n, e;
        src_rand = 1; snk_mode = 1;
        for (int j = 0; j < 5; j++) begin
            n = $urandom_range(1, 5);
            start_job(n);
            wait_done(3000);
            e = data_errs(n);
            n_total++;
            if (e !== 0 || done_cnt !== 1 || words_out !== (NBW+2)'(4 * n)) begin
                n_bad++;
                $display("FAIL random_job%0d: got errs=%0d done=%0d words=%0d want 0 1 %0d",
                         j, e, done_cnt, words_out, 4 * n);
            end
        end
    endtask

    task automatic test_reset_midjob();
        int waited = 0;
        src_rand = 0; snk_mode = 1;
        start_job(4);
        while (wren_cnt < 2 && waited < 200) begin @(negedge clock); waited++; end
        reset = 1'b1;
        #1;
        n_total++;
        if (busy !== 1'b0 || snk_valid !== 1'b0 || src_ready !== 1'b0 || words_out !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got busy=%b sv=%b sr=%b words=%0d want 0 0 0 0",
                     busy, snk_valid, src_ready, words_out);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        done_cnt = 0;
        repeat (10) @(negedge clock);
        n_total++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_nodone: got done=%0d busy=%b want 0 0", done_cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_sink_stall();
        test_inword_full();
        test_outblock_full();
        test_abort();
        test_start_abort_idle();
        test_start_ignored();
        test_random_jobs();
        test_reset_midjob();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
